burst_slave_mem: RTL and testbench

- Downstream slave stage of the interconnect; consumes the burst requests the master FSM issues (address, length, wr/rd, wdata) and returns read data.
- Holds a DEPTH-word register-file memory.
- Write bursts consume one data beat per accepted cycle; read bursts stream data back with a last-beat marker.
- Sits between the interconnect fabric and the storage; it is the final consumer of the request channel.

---
 rtl/interconnect_pkg.sv | 27 ++
 rtl/burst_slave_regfile.sv | 48 ++++
 rtl/burst_slave_mem.sv | 166 ++++++++++++++++
 tb/tb_burst_slave_mem.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interconnect_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : interconnect_pkg                                             |
// | Description : Shared types and constants for the interconnect slave path.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package interconnect_pkg;

  localparam int c_dw = 32;
  localparam int c_aw = 4;
  localparam int c_lw = 4;

  // Request opcode, packed as {wr, rd}
  localparam logic [1:0] c_op_write = 2'b10;
  localparam logic [1:0] c_op_read  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/burst_slave_regfile.sv
// +----------------------------------------------------------------------------+
// | Module      : burst_slave_regfile                                          |
// | Description : DEPTH x DW register array, synchronous write, registered read|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module burst_slave_regfile
  import interconnect_pkg::*;
#(
  parameter int DW = c_dw,
  parameter int AW = c_aw
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Storage is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/burst_slave_mem.sv
// +----------------------------------------------------------------------------+
// | Module      : burst_slave_mem                                              |
// | Description : Burst slave: request FSM, write/read beat streaming, regfile.|
// |               Define BURST_SLAVE_MEM_OOR_ERR_EN to reject bursts that run  |
// |               past the top of memory instead of wrapping.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module burst_slave_mem
  import interconnect_pkg::*;
#(
  parameter int DW = c_dw,
  parameter int AW = c_aw,
  parameter int LW = c_lw
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_req_valid,
  output logic          io_req_ready,
  input  logic          io_req_wr,
  input  logic          io_req_rd,
  input  logic [AW-1:0] io_req_address,
  input  logic [LW-1:0] io_req_length,
  input  logic [DW-1:0] io_wdata,
  input  logic          io_wvalid,
  output logic          io_wready,
  output logic [DW-1:0] io_rdata,
  output logic          io_rvalid,
  input  logic          io_rready,
  output logic          io_rlast,
  output logic          io_done,
  output logic          io_err,
  output logic          io_busy
);

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [LW-1:0] r_cnt;
  logic          r_rvalid;
  logic          r_rlast;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic [1:0]    w_op;
  logic          w_oor;
  logic          w_bad;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_raddr;

  assign io_req_ready = (r_state == ST_IDLE);
  assign io_wready    = (r_state == ST_WRITE);
  assign io_busy      = (r_state != ST_IDLE);
  assign io_rvalid    = r_rvalid;
  assign io_rlast     = r_rlast;
  assign io_done      = r_done;
  assign io_err       = r_err;

  assign w_accept = io_req_valid && io_req_ready;
  assign w_op     = {io_req_wr, io_req_rd};

`ifdef BURST_SLAVE_MEM_OOR_ERR_EN
  localparam int DEPTH = 2**AW;
  localparam int EW    = ((AW > LW) ? AW : LW) + 1;
  logic [EW-1:0] w_end;
  assign w_end = EW'(io_req_address) + EW'(io_req_length);
  assign w_oor = (w_end > EW'(DEPTH));
`else
  assign w_oor = 1'b0;
`endif

  assign w_bad = ((w_op != c_op_write) && (w_op != c_op_read)) ||
                 (io_req_length == '0) || w_oor;

  assign w_we = (r_state == ST_WRITE) && io_wvalid;

  // Prefetch the next word while the current beat is being accepted, so the
  // stream runs at one beat per cycle; hold the read register during a stall.
  assign w_re    = (r_state == ST_READ) &&
                   (!r_rvalid || (io_rready && (r_cnt != LW'(1))));
  assign w_raddr = r_rvalid ? (r_ptr + AW'(1)) : r_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ptr <= io_req_address;
            r_cnt <= io_req_length;
            if (w_bad) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_op == c_op_write) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (io_wvalid) begin
            r_ptr <= r_ptr + AW'(1);
            r_cnt <= r_cnt - LW'(1);
            if (r_cnt == LW'(1)) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_cnt == LW'(1));
          end else if (io_rready) begin
            r_ptr <= r_ptr + AW'(1);
            r_cnt <= r_cnt - LW'(1);
            if (r_cnt == LW'(1)) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= ST_RESP;
              r_done   <= 1'b1;
            end else begin
              r_rlast <= (r_cnt == LW'(2));
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  burst_slave_regfile #(
    .DW (DW),
    .AW (AW)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (io_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (io_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_burst_slave_mem.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_burst_slave_mem                                           |
// | Description : Self-checking bench for burst_slave_mem with a word model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_burst_slave_mem;

  localparam int DEPTH = 16;

  logic        clock;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_wr;
  logic        io_req_rd;
  logic [3:0]  io_req_address;
  logic [3:0]  io_req_length;
  logic [31:0] io_wdata;
  logic        io_wvalid;
  logic        io_wready;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_rready;
  logic        io_rlast;
  logic        io_done;
  logic        io_err;
  logic        io_busy;

  burst_slave_mem dut (
    .clock          (clock),
    .reset          (reset),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_wr      (io_req_wr),
    .io_req_rd      (io_req_rd),
    .io_req_address (io_req_address),
    .io_req_length  (io_req_length),
    .io_wdata       (io_wdata),
    .io_wvalid      (io_wvalid),
    .io_wready      (io_wready),
    .io_rdata       (io_rdata),
    .io_rvalid      (io_rvalid),
    .io_rready      (io_rready),
    .io_rlast       (io_rlast),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_busy        (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              wr;
    logic              rd;
    logic [3:0]        addr;
    logic [3:0]        len;
    logic [15:0][31:0] wd;
    logic              exp_err;
  } vec_t;

  logic [31:0] model [DEPTH];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic spec_err(input logic wr, input logic rd,
                                    input logic [3:0] a, input logic [3:0] l);
    logic e;
    e = (wr == rd) || (l == 4'd0);
`ifdef BURST_SLAVE_MEM_OOR_ERR_EN
    if (int'(a) + int'(l) > DEPTH) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic rd, input logic [3:0] a,
                              input logic [3:0] l, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input logic e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.len = l; v.exp_err = e;
    v.wd = '0;
    v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2; v.wd[3] = d3;
    return v;
  endfunction

  // Called at a negedge with the slave idle; returns at a negedge with the slave idle.
  task automatic run_burst(input logic wr, input logic rd, input logic [3:0] addr,
                           input logic [3:0] len, input logic [15:0][31:0] wd,
                           input logic exp_err, input bit rnd,
                           input int stall_beat, input int stall_cyc);
    int lat, exp_lat, beat, gaps, held, guard;
    bit rdy;
    chk("req_ready_idle", {31'd0, io_req_ready}, 32'd1);
    io_req_valid = 1'b1; io_req_wr = wr; io_req_rd = rd;
    io_req_address = addr; io_req_length = len;
    @(negedge clock);
    // Request pins carry junk from here on; the slave must ignore them.
    io_req_valid = 1'($urandom); io_req_wr = 1'($urandom); io_req_rd = 1'($urandom);
    io_req_address = 4'($urandom); io_req_length = 4'($urandom);
    lat = 1; guard = 0;
    if (exp_err) begin
      exp_lat = 1;
      io_wvalid = 1'b1; io_wdata = wd[0];
    end else if (wr) begin
      beat = 0; gaps = 0;
      while (beat < int'(len) && guard < 200) begin
        chk("wready_in_write", {31'd0, io_wready}, 32'd1);
        chk("no_done_in_write", {31'd0, io_done}, 32'd0);
        if (rnd && $urandom_range(0, 3) == 0) begin
          io_wvalid = 1'b0; io_wdata = $urandom; gaps++;
        end else begin
          io_wvalid = 1'b1; io_wdata = wd[beat];
          model[(int'(addr) + beat) % DEPTH] = wd[beat];
          beat++;
        end
        io_rready = 1'($urandom);
        @(negedge clock); lat++; guard++;
      end
      if (guard >= 200) chk("write_timeout", 32'd1, 32'd0);
      io_wvalid = 1'b0;
      exp_lat = int'(len) + gaps + 1;
    end else begin
      chk("rvalid_first_cycle", {31'd0, io_rvalid}, 32'd0);
      io_wvalid = 1'b1; io_wdata = $urandom;
      @(negedge clock); lat++;
      beat = 0; gaps = 0; held = 0;
      while (beat < int'(len) && guard < 200) begin
        chk("rvalid", {31'd0, io_rvalid}, 32'd1);
        chk("rdata", io_rdata, model[(int'(addr) + beat) % DEPTH]);
        chk("rlast", {31'd0, io_rlast}, {31'd0, beat == int'(len) - 1});
        if (beat == stall_beat && held < stall_cyc) begin
          rdy = 1'b0; held++;
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          rdy = 1'b0;
        end else begin
          rdy = 1'b1;
        end
        io_rready = rdy;
        if (rdy) beat++; else gaps++;
        io_wvalid = 1'($urandom); io_wdata = $urandom;
        @(negedge clock); lat++; guard++;
      end
      if (guard >= 200) chk("read_timeout", 32'd1, 32'd0);
      exp_lat = int'(len) + 2 + gaps;
    end
    chk("done", {31'd0, io_done}, 32'd1);
    chk("err", {31'd0, io_err}, {31'd0, exp_err});
    chk("latency", lat, exp_lat);
    chk("rvalid_in_resp", {31'd0, io_rvalid}, 32'd0);
    chk("wready_in_resp", {31'd0, io_wready}, 32'd0);
    chk("req_ready_in_resp", {31'd0, io_req_ready}, 32'd0);
    io_req_valid = 1'b0; io_wvalid = 1'b0; io_rready = 1'b0;
    @(negedge clock);
    chk("done_pulse_end", {31'd0, io_done}, 32'd0);
    chk("err_pulse_end", {31'd0, io_err}, 32'd0);
    chk("busy_after", {31'd0, io_busy}, 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    logic [15:0][31:0] pre;
    reset = 1'b0;
    io_req_valid = 1'b0; io_req_wr = 1'b0; io_req_rd = 1'b0;
    io_req_address = '0; io_req_length = '0;
    io_wdata = '0; io_wvalid = 1'b0; io_rready = 1'b0;

    vecs[0]  = mk(1, 0, 4'h7, 4'd4, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0);
    vecs[1]  = mk(0, 1, 4'h7, 4'd4, 0, 0, 0, 0, 1'b0);
`ifdef BURST_SLAVE_MEM_OOR_ERR_EN
    vecs[2]  = mk(1, 0, 4'hE, 4'd3, 32'h1, 32'h2, 32'h3, 0, 1'b1);
`else
    vecs[2]  = mk(1, 0, 4'hE, 4'd3, 32'h1, 32'h2, 32'h3, 0, 1'b0);
`endif
    vecs[3]  = mk(0, 1, 4'hD, 4'd3, 0, 0, 0, 0, 1'b0);
    vecs[4]  = mk(0, 1, 4'h0, 4'd1, 0, 0, 0, 0, 1'b0);
    vecs[5]  = mk(1, 1, 4'h2, 4'd2, 32'hDEAD, 32'hBEEF, 0, 0, 1'b1);
    vecs[6]  = mk(0, 0, 4'h2, 4'd2, 32'h5555, 0, 0, 0, 1'b1);
    vecs[7]  = mk(1, 0, 4'h5, 4'd0, 32'h7777, 0, 0, 0, 1'b1);
    vecs[8]  = mk(0, 1, 4'h5, 4'd0, 0, 0, 0, 0, 1'b1);
    vecs[9]  = mk(0, 1, 4'h2, 4'd2, 0, 0, 0, 0, 1'b0);
    vecs[10] = mk(1, 0, 4'hF, 4'd1, 32'h99, 0, 0, 0, 1'b0);
    vecs[11] = mk(0, 1, 4'hE, 4'd2, 0, 0, 0, 0, 1'b0);

    repeat (2) @(negedge clock);
    chk("rst_rvalid", {31'd0, io_rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, io_rlast}, 32'd0);
    chk("rst_done", {31'd0, io_done}, 32'd0);
    chk("rst_err", {31'd0, io_err}, 32'd0);
    chk("rst_wready", {31'd0, io_wready}, 32'd0);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_busy", {31'd0, io_busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("req_ready_after_rst", {31'd0, io_req_ready}, 32'd1);

    // Give every word a known value before anything is read back.
    for (int i = 0; i < 16; i++) pre[i] = $urandom;
    run_burst(1, 0, 4'h0, 4'd15, pre, 1'b0, 1'b0, -1, 0);
    pre[0] = $urandom;
    run_burst(1, 0, 4'hF, 4'd1, pre, 1'b0, 1'b0, -1, 0);

    for (int i = 0; i < 12; i++) begin
      run_burst(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].len, vecs[i].wd,
                vecs[i].exp_err, 1'b0, -1, 0);
    end

    // Rewrite 7..A, then read it with a two-cycle stall on the second beat.
    run_burst(vecs[0].wr, vecs[0].rd, vecs[0].addr, vecs[0].len, vecs[0].wd, 1'b0, 1'b0, -1, 0);
    run_burst(0, 1, 4'h7, 4'd4, pre, 1'b0, 1'b0, 1, 2);

    // Reset arrives while the second write beat is on the bus.
    io_req_valid = 1'b1; io_req_wr = 1'b1; io_req_rd = 1'b0;
    io_req_address = 4'h3; io_req_length = 4'd4;
    @(negedge clock);
    io_req_valid = 1'b0;
    io_wvalid = 1'b1; io_wdata = 32'h1234_5678;
    model[3] = 32'h1234_5678;
    @(negedge clock);
    io_wdata = 32'hFEED_F00D;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, io_busy}, 32'd0);
    chk("async_rst_wready", {31'd0, io_wready}, 32'd0);
    chk("async_rst_done", {31'd0, io_done}, 32'd0);
    chk("async_rst_rvalid", {31'd0, io_rvalid}, 32'd0);
    @(negedge clock);
    io_wvalid = 1'b0;
    chk("rst_hold_done", {31'd0, io_done}, 32'd0);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("req_ready_after_abort", {31'd0, io_req_ready}, 32'd1);
    chk("done_after_abort", {31'd0, io_done}, 32'd0);
    run_burst(0, 1, 4'h3, 4'd2, pre, 1'b0, 1'b0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0][31:0] wd;
      logic wr, rd;
      logic [3:0] a, l;
      int r;
      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin wr = 1; rd = 1; end
      else if (r == 1) begin wr = 0; rd = 0; end
      else begin wr = r[0]; rd = !r[0]; end
      a = 4'($urandom);
      l = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      run_burst(wr, rd, a, l, wd, spec_err(wr, rd, a, l), 1'b1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
